count_bcd_display: RTL

- Downstream consumer of the tt_um_counter count value.
- Converts each presented binary count to packed BCD with a sequential double-dabble engine, one iteration per cycle.
- Drives a time-multiplexed common-cathode 7-segment display with leading-zero blanking.
- Sits between the counter core and the uo_out/uio_out pad mapping in the top-level wrapper.

---
 rtl/count_bcd_display.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/count_bcd_display.sv
// count_bcd_display
// Converts a binary count to packed BCD with a sequential double-dabble
// engine (one iteration per clock) and drives a time-multiplexed
// common-cathode 7-segment display with leading-zero blanking.
module count_bcd_display #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 1024,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      value_in,
  input  logic                  value_valid,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int ITER_W = $clog2(WIDTH + 1);
  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  bin_reg;
  logic [BCD_W-1:0]  scratch;
  logic [BCD_W-1:0]  scratch_adj;
  logic [ITER_W-1:0] iter;
  logic [CNT_W-1:0]  refresh_cnt;
  logic [IDX_W-1:0]  digit_idx;
  logic [DIGITS-1:0] lead_zero;
  logic              zero_run;
  logic [3:0]        nibble;
  logic              blank;
  logic [6:0]        seg_raw;
  logic [DIGITS-1:0] sel_raw;

  // Double-dabble correction: every scratch nibble of 5 or more gets +3
  // so that the following left shift carries correctly into the next digit.
  always_comb begin
    scratch_adj = scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) begin
        scratch_adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: capture in IDLE, WIDTH correct-and-shift steps, publish in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bin_reg   <= '0;
      scratch   <= '0;
      iter      <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (value_valid) begin
            bin_reg <= value_in;
            scratch <= '0;
            iter    <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {scratch_adj[BCD_W-2:0], bin_reg[WIDTH-1]};
          bin_reg <= {bin_reg[WIDTH-2:0], 1'b0};
          iter    <= iter + 1'b1;
          if (iter == ITER_W'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd_out   <= scratch;
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Free-running display refresh: each digit stays selected for REFRESH_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Mark each position whose digit and all higher digits are zero.
  always_comb begin
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run & (bcd_out[4*k +: 4] == 4'd0);
      lead_zero[k] = zero_run;
    end
  end

  // Pick the selected digit from the published result; the ones digit is never blanked.
  always_comb begin
    nibble  = '0;
    blank   = 1'b0;
    sel_raw = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        nibble     = bcd_out[4*k +: 4];
        blank      = (k != 0) && lead_zero[k];
        sel_raw[k] = 1'b1;
      end
    end
  end

  // Segment decode, seg[0]=a .. seg[6]=g, active-high before polarity handling.
  always_comb begin
    case (nibble)
      4'd0:    seg_raw = 7'h3F;
      4'd1:    seg_raw = 7'h06;
      4'd2:    seg_raw = 7'h5B;
      4'd3:    seg_raw = 7'h4F;
      4'd4:    seg_raw = 7'h66;
      4'd5:    seg_raw = 7'h6D;
      4'd6:    seg_raw = 7'h7D;
      4'd7:    seg_raw = 7'h07;
      4'd8:    seg_raw = 7'h7F;
      4'd9:    seg_raw = 7'h6F;
      default: seg_raw = 7'h00;
    endcase
    if (blank) begin
      seg_raw = 7'h00;
    end
  end

  assign seg       = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
  assign digit_sel = (ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
  assign dp        = (ACTIVE_LOW != 0);

endmodule
